// File: rtl/read_pointers.sv
// Read-side pointer and occupancy stage of the single-clock FIFO.
// Tracks the head address, issues registered RAM read address/enable,
// delays the enable to mark RAM data valid, and keeps occupancy and
// sticky overflow/underflow flags. Status outputs decode only registers.
module read_pointers #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] r_add,
  output logic              r_en,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_ok;
  logic              push_ok;
  logic              ovf_set;
  logic              unf_set;

  // full/empty come from the count register only, so no input-to-output path
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push while full is still accepted when a pop frees a slot the same edge
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_set = push & full & ~pop_ok;
  assign unf_set = pop & empty;

  // Head pointer and RAM read port; pointer wraps naturally at ADDR_W bits
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      r_add    <= '0;
      r_en     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= r_en;
      r_en     <= pop_ok;
      if (pop_ok) begin
        r_add  <= rd_ptr;
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous accepted push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_read_pointers.sv
// Scoreboard bench for read_pointers: stimulus process runs an occupancy
// model and queues expected outputs tagged with the cycle they must appear;
// a monitor on the falling edge pops and compares.
module tb_read_pointers;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset, push, pop, err_clr;
  logic [ADDR_W-1:0] r_add;
  logic              r_en, rd_valid;
  logic [ADDR_W:0]   count;
  logic              full, empty, ovf, unf;

  read_pointers #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .err_clr(err_clr),
    .r_add(r_add), .r_en(r_en), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; } rd_exp_t;
  typedef struct { int cyc; int cnt; bit fl; bit em; bit ov; bit un; int radd; } st_exp_t;

  rd_exp_t q_ren[$];
  rd_exp_t q_vld[$];
  st_exp_t q_st[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit armed = 0;
  int max_cnt_seen = 0;

  // model state
  int m_cnt = 0, m_head = 0, m_radd = 0;
  bit m_ovf = 0, m_unf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Monitor: compare whatever is due this cycle
  always @(negedge clk) begin
    if (armed) begin
      if (q_ren.size() > 0 && q_ren[0].cyc == cyc) begin
        chk("r_en", longint'(r_en), 1);
        chk("r_add", longint'(r_add), q_ren[0].addr);
        void'(q_ren.pop_front());
      end else begin
        chk("r_en_idle", longint'(r_en), 0);
      end
      if (q_vld.size() > 0 && q_vld[0].cyc == cyc) begin
        chk("rd_valid", longint'(rd_valid), 1);
        void'(q_vld.pop_front());
      end else begin
        chk("rd_valid_idle", longint'(rd_valid), 0);
      end
      if (q_st.size() > 0 && q_st[0].cyc == cyc) begin
        chk("count", longint'(count), q_st[0].cnt);
        chk("flags", longint'({full, empty, ovf, unf}),
            longint'({q_st[0].fl, q_st[0].em, q_st[0].ov, q_st[0].un}));
        chk("r_add_hold", longint'(r_add), q_st[0].radd);
        void'(q_st.pop_front());
      end
    end
  end

  // One clock of stimulus; model computes the state after the next edge
  task automatic step(input bit rst, input bit ps, input bit pp, input bit clr);
    bit pop_ok, push_ok;
    st_exp_t s;
    @(negedge clk);
    reset = rst; push = ps; pop = pp; err_clr = clr;
    if (rst) begin
      m_cnt = 0; m_head = 0; m_radd = 0; m_ovf = 0; m_unf = 0;
      // reads in flight are discarded
      while (q_ren.size() > 0 && q_ren[$].cyc > cyc) void'(q_ren.pop_back());
      while (q_vld.size() > 0 && q_vld[$].cyc > cyc) void'(q_vld.pop_back());
    end else begin
      pop_ok  = pp && (m_cnt > 0);
      push_ok = ps && (m_cnt < DEPTH || pop_ok);
      m_ovf = (ps && m_cnt == DEPTH && !pop_ok) || (m_ovf && !clr);
      m_unf = (pp && m_cnt == 0) || (m_unf && !clr);
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
      if (pop_ok) begin
        q_ren.push_back('{cyc + 1, m_head});
        q_vld.push_back('{cyc + 2, m_head});
        m_radd = m_head;
        m_head = (m_head + 1) % DEPTH;
      end
    end
    if (m_cnt > max_cnt_seen) max_cnt_seen = m_cnt;
    s = '{cyc + 1, m_cnt, m_cnt == DEPTH, m_cnt == 0, m_ovf, m_unf, m_radd};
    q_st.push_back(s);
    @(posedge clk);
    if (rst) armed = 1;
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; err_clr = 0;
    step(1, 0, 0, 0);
    // three pushes
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // fill, overflow, clear
    step(1, 0, 0, 0);
    repeat (16) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // underflow on empty
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // two pushes then back-to-back pops
    step(1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // 20 push/pop pairs through the wrap
    step(1, 0, 0, 0);
    max_cnt_seen = 0;
    repeat (20) begin step(0, 1, 0, 0); step(0, 0, 1, 0); end
    chk("pair_max_count", max_cnt_seen, 1);
    repeat (2) step(0, 0, 0, 0);
    // full with simultaneous push+pop
    step(1, 0, 0, 0);
    repeat (16) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    // reset while pops are in flight
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
    end
    repeat (4) step(0, 0, 0, 0);
    chk("ren_queue_drained", q_ren.size(), 0);
    chk("vld_queue_drained", q_vld.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/read_pointers.md
# read_pointers

Read-side pointer and occupancy stage of the single-clock FIFO. It sits beside the write-pointer stage, observes the same `push` strobe, accepts `pop` requests, and drives read address/enable into the dual-port RAM. It produces a data-valid strobe aligned to the RAM's one-cycle read latency, plus full/empty/count status and sticky overflow/underflow error flags.

## Interface
- `ADDR_W`, default 4: RAM address width; FIFO depth `DEPTH = 2**ADDR_W` (16).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write strobe, the same signal that drives the write-pointer stage.
- `pop`  in  1  read request from the consumer.
- `err_clr`  in  1  clears the sticky error flags.
- `r_add`  out  ADDR_W  RAM read address; registered.
- `r_en`  out  1  RAM read enable; registered one-cycle pulse per accepted pop.
- `rd_valid`  out  1  RAM read data valid; `r_en` delayed one cycle.
- `count`  out  ADDR_W+1  occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky overflow flag.
- `unf`  out  1  sticky underflow flag.

## Operation
- Internal `rd_ptr` (ADDR_W bits, reset 0) holds the head address.
- `pop_ok = pop & !empty`.
- `push_ok = push & (!full | pop_ok)`.
- On `pop_ok`:
  - `r_add <= rd_ptr`.
  - `rd_ptr <= rd_ptr + 1`, modulo DEPTH, so 15 wraps to 0 with no extra state.
  - `r_en <= 1`.
- Without `pop_ok`: `r_en <= 0` and `r_add` holds its value.
- `rd_valid <= r_en` every cycle.
- Count update:
  - `push_ok & !pop_ok`: +1.
  - `pop_ok & !push_ok`: −1.
  - Both or neither: unchanged.
- `count` never leaves 0..DEPTH.
- `full` and `empty` are decoded from the `count` register, so they change only on clock edges and carry no combinational path from `push` or `pop`.
- Error flags:
  - `ovf` sets on `push & full & !pop_ok`. `count` is unchanged.
  - `unf` sets on `pop & empty`. The pop is ignored: no `r_en`, `rd_ptr` holds.
  - `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, the set wins.
- No fall-through: push and pop while empty means the push is accepted, the pop is rejected, `unf` sets and `count` goes to 1.
- Push and pop while full: both are accepted, `count` stays DEPTH, no `ovf`.
- After an overflow, the write-side pointer has advanced anyway, so FIFO contents are invalid. `ovf` is a fatal indication; recovery is `reset` only.

## Timing
- Reset values, one edge after `reset` is high:
  - `r_add = 0`, `r_en = 0`, `rd_valid = 0`.
  - `count = 0`, `full = 0`, `empty = 1`.
  - `ovf = 0`, `unf = 0`, `rd_ptr = 0`.
- Reset has priority over all inputs.
- Reset mid-operation flushes any in-flight `r_en`/`rd_valid` and discards their data.
- Accepted pop sampled at edge N:
  - `r_en = 1` and `r_add` valid during cycle N+1.
  - `rd_valid = 1` during cycle N+2, when the RAM data is on the bus.
- Back-to-back pops, one per cycle, are supported with no bubbles. `r_add` increments by 1 each cycle.
- `count`, `full` and `empty` reflect an edge-N push/pop in cycle N+1.
- `ovf` and `unf` assert in the cycle after the offending edge.

## Test plan
- Reset, then 3 pushes on consecutive cycles -> `count = 3`, `empty = 0`, `full = 0`; `r_en`, `rd_valid`, `ovf` and `unf` all stay 0.
- 16 pushes -> `full = 1`, `count = 16`; 17th push -> `ovf = 1`, `count = 16`; `err_clr` pulse -> `ovf = 0`.
- Pop after reset while empty -> `unf = 1`, `r_en = 0`, `r_add = 0`, `count = 0`.
- 2 pushes, then pops at edges N and N+1:
  - `r_en = 1` in cycles N+1 and N+2, with `r_add = 0` then `1`.
  - `rd_valid = 1` in cycles N+2 and N+3.
  - `count = 0`, `empty = 1` from cycle N+2.
- 20 push/pop pairs -> `r_add` sequence runs 0..15, 0..3 (wrap at 15→0); `count` never exceeds 1.
- Fill to 16, then simultaneous push+pop -> `count = 16`, `ovf = 0`, `r_en = 1`.
- Reset asserted while pops are in flight -> `r_en = 0` and `rd_valid = 0` in the next cycle, plus all reset values.
